// File: rtl/dmem_responder.sv
// Data-side memory responder for the single-cycle RISC-V core.
// Serves byte-addressed loads (combinational, with sub-word extraction and
// sign/zero extension) and stores (byte-lane writes on the rising edge) to a
// word-organised RAM, plus a 16-byte MMIO window:
//   +0x0 cycle[31:0] (RO), +0x4 cycle[63:32] (RO), +0x8 tohost, +0xC err (W1C).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   MemWrite            - store request this cycle
//   ALUResult           - byte address
//   WriteData           - store data, sub-word data right-aligned
//   AccessMode          - 00 byte, 01 half, 10 word, 11 reserved
//   DataExtendMode      - load extension: 0 sign, 1 zero
//   ReadData            - load data
//   done, tohost        - set/captured by a store to tohost
//   err                 - sticky store errors {rsvd mode, out of range, misaligned}
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [1:0]  AccessMode,
  input  logic        DataExtendMode,
  output logic [31:0] ReadData,
  output logic        done,
  output logic [31:0] tohost,
  output logic [2:0]  err
);

  localparam int unsigned RamBytes = DEPTH_WORDS * 4;
  localparam int unsigned AddrW    = $clog2(RamBytes);

  localparam logic [1:0] ModeByte = 2'b00;
  localparam logic [1:0] ModeHalf = 2'b01;
  localparam logic [1:0] ModeWord = 2'b10;
  localparam logic [1:0] ModeRsvd = 2'b11;

  logic [31:0] mem [DEPTH_WORDS];

  logic [63:0] cycle_q, cycle_d;
  logic        done_q, done_d;
  logic [31:0] tohost_q, tohost_d;
  logic [2:0]  err_q, err_d;

  logic              mmio_hit, ram_sel, aligned, rsvd;
  logic [AddrW-3:0]  word_idx;
  logic [31:0]       rd_word, rd_shift;
  logic [3:0]        byte_en;
  logic [31:0]       wr_lanes;
  logic              ram_we, tohost_we, err_clr;
  logic [2:0]        err_set;

  assign mmio_hit = (ALUResult[31:4] == MMIO_BASE[31:4]);
  // MMIO wins if the window ever overlaps RAM.
  assign ram_sel  = (ALUResult < 32'(RamBytes)) && !mmio_hit;
  assign rsvd     = (AccessMode == ModeRsvd);
  assign word_idx = ALUResult[AddrW-1:2];

  always_comb begin
    aligned = 1'b1;
    unique case (AccessMode)
      ModeHalf: aligned = !ALUResult[0];
      ModeWord: aligned = (ALUResult[1:0] == 2'b00);
      default:  aligned = 1'b1;
    endcase
  end

  // Store decode: errors in priority order, each one suppresses the store.
  always_comb begin
    err_set   = '0;
    ram_we    = 1'b0;
    tohost_we = 1'b0;
    err_clr   = 1'b0;
    if (MemWrite) begin
      if (rsvd) begin
        err_set[2] = 1'b1;
      end else if (!aligned) begin
        err_set[0] = 1'b1;
      end else if (mmio_hit) begin
        if (AccessMode != ModeWord) begin
          err_set[0] = 1'b1;
        end else begin
          unique case (ALUResult[3:2])
            2'b10:   tohost_we = 1'b1;
            2'b11:   err_clr   = 1'b1;
            default: ;
          endcase
        end
      end else if (ram_sel) begin
        ram_we = 1'b1;
      end else begin
        err_set[1] = 1'b1;
      end
    end
  end

  // Replicate sub-word data across lanes; byte_en picks which lanes land.
  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = WriteData;
    unique case (AccessMode)
      ModeByte: begin
        byte_en  = 4'b0001 << ALUResult[1:0];
        wr_lanes = {4{WriteData[7:0]}};
      end
      ModeHalf: begin
        byte_en  = ALUResult[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{WriteData[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = WriteData;
      end
    endcase
  end

  // RAM is not reset; a store during reset is discarded.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
      end
    end
  end

  always_comb begin
    cycle_d  = cycle_q + 64'd1;
    done_d   = done_q | tohost_we;
    tohost_d = tohost_we ? WriteData : tohost_q;
    err_d    = (err_q & ~(err_clr ? WriteData[2:0] : 3'b000)) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      done_q   <= 1'b0;
      tohost_q <= '0;
      err_q    <= '0;
    end else begin
      cycle_q  <= cycle_d;
      done_q   <= done_d;
      tohost_q <= tohost_d;
      err_q    <= err_d;
    end
  end

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {ALUResult[1:0], 3'b000};

  // Loads never flag errors; anything illegal reads as zero.
  always_comb begin
    ReadData = '0;
    if (!rsvd && aligned) begin
      if (mmio_hit) begin
        if (AccessMode == ModeWord) begin
          unique case (ALUResult[3:2])
            2'b00:   ReadData = cycle_q[31:0];
            2'b01:   ReadData = cycle_q[63:32];
            2'b10:   ReadData = tohost_q;
            default: ReadData = {29'b0, err_q};
          endcase
        end
      end else if (ram_sel) begin
        unique case (AccessMode)
          ModeByte: ReadData = {{24{!DataExtendMode && rd_shift[7]}}, rd_shift[7:0]};
          ModeHalf: ReadData = {{16{!DataExtendMode && rd_shift[15]}}, rd_shift[15:0]};
          default:  ReadData = rd_word;
        endcase
      end
    end
  end

  assign done   = done_q;
  assign tohost = tohost_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DepthWords = 1024;
  localparam int unsigned RamBytes   = DepthWords * 4;
  localparam logic [31:0] Mmio       = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [1:0]  mode = 2'b10;
  logic        ext = 1'b0;
  logic [31:0] rdata;
  logic        done;
  logic [31:0] tohost;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model state.
  logic [7:0]  mbyte  [RamBytes];
  bit          mvalid [RamBytes];
  logic        mdone = 1'b0;
  logic [31:0] mtohost = '0;
  logic [2:0]  merr = '0;
  logic [63:0] mcnt = '0;

  dmem_responder #(
    .DEPTH_WORDS(DepthWords),
    .MMIO_BASE  (Mmio)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (we),
    .ALUResult     (addr),
    .WriteData     (wd),
    .AccessMode    (mode),
    .DataExtendMode(ext),
    .ReadData      (rdata),
    .done          (done),
    .tohost        (tohost),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] m);
    if (m == 2'd3) return 1'b0;
    if (m == 2'd1) return a[0] == 1'b0;
    if (m == 2'd2) return a[1:0] == 2'b00;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] m,
                                             input logic e, output bit known);
    logic [31:0] v;
    int n;
    known = 1'b1;
    v = '0;
    if (!is_aligned(a, m)) return '0;
    if (a[31:4] == Mmio[31:4]) begin
      if (m != 2'd2) return '0;
      case (a[3:0])
        4'h0:    return mcnt[31:0];
        4'h4:    return mcnt[63:32];
        4'h8:    return mtohost;
        default: return {29'b0, merr};
      endcase
    end
    if (a >= RamBytes) return '0;
    n = 1 << m;
    for (int i = 0; i < n; i++) begin
      if (!mvalid[int'(a) + i]) known = 1'b0;
      v = v | (32'(mbyte[int'(a) + i]) << (8 * i));
    end
    if (!e && m == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (!e && m == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store();
    if (mode == 2'd3) begin
      merr = merr | 3'b100;
    end else if (!is_aligned(addr, mode)) begin
      merr = merr | 3'b001;
    end else if (addr[31:4] == Mmio[31:4]) begin
      if (mode != 2'd2) merr = merr | 3'b001;
      else if (addr[3:0] == 4'h8) begin
        mtohost = wd;
        mdone   = 1'b1;
      end else if (addr[3:0] == 4'hC) begin
        merr = merr & ~wd[2:0];
      end
    end else if (addr < RamBytes) begin
      for (int i = 0; i < (1 << mode); i++) begin
        mbyte[int'(addr) + i]  = wd[8*i +: 8];
        mvalid[int'(addr) + i] = 1'b1;
      end
    end else begin
      merr = merr | 3'b010;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdone = 1'b0;
      mtohost = '0;
      merr = '0;
      mcnt = '0;
    end else begin
      mcnt = mcnt + 64'd1;
      if (we) model_store();
    end
  end

  // Compare process: inputs change just after the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      bit known;
      logic [31:0] exp;
      exp = model_load(addr, mode, ext, known);
      if (known) check("rdata", rdata, exp);
      check("done", 32'(done), 32'(mdone));
      check("tohost", tohost, mtohost);
      check("err", 32'(err), 32'(merr));
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] m, input logic e);
    @(posedge clk);
    #1;
    we = w;
    addr = a;
    wd = d;
    mode = m;
    ext = e;
  endtask

  task automatic load_chk(input string name, input logic [31:0] a, input logic [1:0] m,
                          input logic e, input logic [31:0] exp);
    drive(1'b0, a, '0, m, e);
    @(negedge clk);
    check(name, rdata, exp);
  endtask

  logic [31:0] lit_sx [4] = '{32'hFFFF_FFEF, 32'hFFFF_FFBE, 32'hFFFF_FFAD, 32'hFFFF_FFDE};
  logic [31:0] lit_zx [4] = '{32'h0000_00EF, 32'h0000_00BE, 32'h0000_00AD, 32'h0000_00DE};

  initial begin
    for (int i = 0; i < int'(RamBytes); i++) mvalid[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Byte extraction and extension.
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) load_chk("byte_sx", 32'h10 + i, 2'd0, 1'b0, lit_sx[i]);
    for (int i = 0; i < 4; i++) load_chk("byte_zx", 32'h10 + i, 2'd0, 1'b1, lit_zx[i]);

    // Half store over a word.
    drive(1'b1, 32'h20, 32'h1122_3344, 2'd2, 1'b0);
    drive(1'b1, 32'h22, 32'h0000_8001, 2'd1, 1'b0);
    load_chk("half_word", 32'h20, 2'd2, 1'b0, 32'h8001_3344);
    load_chk("half_sx", 32'h22, 2'd1, 1'b0, 32'hFFFF_8001);
    load_chk("half_zx", 32'h22, 2'd1, 1'b1, 32'h0000_8001);

    // Error paths.
    drive(1'b1, 32'h21, 32'hCAFE_F00D, 2'd2, 1'b0);
    load_chk("misal_ram", 32'h20, 2'd2, 1'b0, 32'h8001_3344);
    check("misal_err", 32'(err), 32'd1);
    drive(1'b1, Mmio + 32'hC, 32'h1, 2'd2, 1'b0);
    drive(1'b0, 32'h0, '0, 2'd2, 1'b0);
    @(negedge clk);
    check("w1c_err", 32'(err), 32'd0);
    drive(1'b1, 32'h4000_0000, 32'h5, 2'd2, 1'b0);
    drive(1'b0, 32'h0, '0, 2'd2, 1'b0);
    @(negedge clk);
    check("oor_err", 32'(err), 32'd2);
    drive(1'b1, 32'h30, 32'h5, 2'd3, 1'b0);
    drive(1'b0, 32'h0, '0, 2'd2, 1'b0);
    @(negedge clk);
    check("rsvd_err", 32'(err), 32'd6);
    drive(1'b1, Mmio + 32'hC, 32'h7, 2'd2, 1'b0);

    // tohost.
    drive(1'b1, Mmio + 32'h8, 32'h2A, 2'd2, 1'b0);
    drive(1'b1, Mmio + 32'h8, 32'h55, 2'd0, 1'b0);
    @(negedge clk);
    check("tohost_done", 32'(done), 32'd1);
    check("tohost_val", tohost, 32'h2A);
    drive(1'b0, 32'h0, '0, 2'd2, 1'b0);
    @(negedge clk);
    check("tohost_byte", tohost, 32'h2A);
    check("tohost_byte_err", 32'(err), 32'd1);

    // Cycle counter from reset.
    @(negedge clk);
    #1 reset = 1'b1;
    we = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    addr = Mmio;
    mode = 2'd2;
    repeat (100) @(posedge clk);
    #2 check("cnt_lo", rdata, 32'd100);
    addr = Mmio + 32'h4;
    #1 check("cnt_hi", rdata, 32'd0);

    // Counter wrap.
    @(negedge clk);
    #1 force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    mcnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cycle_q;
    addr = Mmio;
    #1 check("cnt_max", rdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #2 check("wrap_lo", rdata, 32'd0);
    addr = Mmio + 32'h4;
    #1 check("wrap_hi", rdata, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      logic [1:0]  m;
      int r;
      r = int'($urandom_range(0, 9));
      m = (r == 0) ? 2'd3 : (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : 2'd2;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 255));
        6:       a = Mmio | 32'($urandom_range(0, 15));
        7:       a = RamBytes - 8 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 3) != 0 && m != 2'd3) a = a & ~((32'd1 << m) - 32'd1);
      drive(($urandom_range(0, 9) < 4), a, $urandom, m, 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-cycle while a tohost store is pending.
    drive(1'b1, 32'h40, 32'h1234_5678, 2'd2, 1'b0);
    drive(1'b1, 32'h44, 32'h0, 2'd3, 1'b0);
    drive(1'b1, Mmio + 32'h8, 32'h77, 2'd2, 1'b0);
    drive(1'b1, Mmio + 32'h8, 32'h99, 2'd2, 1'b0);
    #2 reset = 1'b1;
    #1 check("rst_done", 32'(done), 32'd0);
    check("rst_tohost", tohost, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    addr = 32'h40;
    wd = 32'hBBBB_BBBB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    we = 1'b0;
    #1 check("rst_ram", rdata, 32'h1234_5678);
    check("rst_done2", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
